// File: rtl/display_pkg.sv
// Shared 640x480@60 timing constants, 40x30 cell-grid geometry and the
// cell address helper used by the framebuffer scanout.
package display_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t H_VISIBLE    = 10'd640;
    localparam coord_t H_FRONT      = 10'd16;
    localparam coord_t H_SYNC       = 10'd96;
    localparam coord_t H_BACK       = 10'd48;
    localparam coord_t H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam coord_t H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam coord_t H_LAST       = H_TOTAL - 10'd1;

    localparam coord_t V_VISIBLE    = 10'd480;
    localparam coord_t V_FRONT      = 10'd10;
    localparam coord_t V_SYNC       = 10'd2;
    localparam coord_t V_BACK       = 10'd33;
    localparam coord_t V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;
    localparam coord_t V_LAST       = V_TOTAL - 10'd1;

    localparam logic [10:0] GRID_W     = 11'd40;
    localparam logic [10:0] GRID_H     = 11'd30;
    localparam int          CELL_SHIFT = 4;
    localparam int          FB_BITS    = 1200;

    // Only meaningful for visible positions, where the result is at most 1199.
    function automatic logic [10:0] cell_addr(input coord_t h, input coord_t v);
        logic [10:0] row;
        logic [10:0] col;
        row = 11'(v >> CELL_SHIFT);
        col = 11'(h >> CELL_SHIFT);
        return row * GRID_W + col;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, horizontal/vertical scan counters and the combinational
// sync / visible-area decode of the current scan position.
module vga_timing
    import display_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic   clock,
    input  logic   reset_n,
    output logic   tick,
    output coord_t hcount,
    output coord_t vcount,
    output logic   visible,
    output logic   hs_n,
    output logic   vs_n,
    output logic   frame_wrap
);

    logic [3:0] div_q;
    coord_t     h_q;
    coord_t     v_q;

    assign tick = (div_q == 4'(CLK_DIV - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= tick ? 4'd0 : div_q + 4'd1;
            if (tick) begin
                if (h_q == H_LAST) begin
                    h_q <= '0;
                    v_q <= (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
                end else begin
                    h_q <= h_q + 10'd1;
                end
            end
        end
    end

    assign hcount     = h_q;
    assign vcount     = v_q;
    assign visible    = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
    assign hs_n       = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
    assign vs_n       = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
    // The tick that takes the scan from (799,524) back to (0,0).
    assign frame_wrap = tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/framebuffer_scanout.sv
// 40x30 one-bit framebuffer to 640x480 VGA scanout, 16x16 pixels per cell.
// Define SCANOUT_SHADOW_EN to scan from a per-frame shadow copy (tear-free).
module framebuffer_scanout
    import display_pkg::*;
#(
    parameter int          CLK_DIV  = 2,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [FB_BITS-1:0] framebuffer,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               frame_start
);

    logic   tick;
    coord_t hcount;
    coord_t vcount;
    logic   visible;
    logic   hs_n;
    logic   vs_n;
    logic   frame_wrap;

    vga_timing #(
        .CLK_DIV(CLK_DIV)
    ) u_timing (
        .clock     (clock),
        .reset_n   (reset_n),
        .tick      (tick),
        .hcount    (hcount),
        .vcount    (vcount),
        .visible   (visible),
        .hs_n      (hs_n),
        .vs_n      (vs_n),
        .frame_wrap(frame_wrap)
    );

    logic [FB_BITS-1:0] pixel_src;

`ifdef SCANOUT_SHADOW_EN
    logic [FB_BITS-1:0] shadow_q;

    // Captured on the last tick of a frame so the next frame sees one snapshot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
        end else if (frame_wrap) begin
            shadow_q <= framebuffer;
        end
    end

    assign pixel_src = shadow_q;
`else
    assign pixel_src = framebuffer;
`endif

    logic [10:0] addr;
    logic        pixel_bit;
    logic [11:0] colour;

    // Address is only formed inside the visible area, keeping the index below 1200.
    always_comb begin
        addr      = '0;
        pixel_bit = 1'b0;
        colour    = 12'h000;
        if (visible) begin
            addr      = cell_addr(hcount, vcount);
            pixel_bit = pixel_src[addr];
            colour    = pixel_bit ? FG_COLOR : BG_COLOR;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (tick) begin
                {vga_r, vga_g, vga_b} <= colour;
                vga_hs                <= hs_n;
                vga_vs                <= vs_n;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout: one instance at CLK_DIV=2, one at
// CLK_DIV=1, with the scan position moved by forcing the timing counters.
module tb_framebuffer_scanout;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [1199:0] fb;
    logic [3:0]    r0, g0, b0, r1, g1, b1;
    logic          hs0, vs0, fs0, hs1, vs1, fs1;
    logic [9:0]    jump_h, jump_v;
    int            n_checks = 0;
    int            n_fail   = 0;

    framebuffer_scanout #(.CLK_DIV(2)) dut (
        .clock(clock), .reset_n(reset_n), .framebuffer(fb),
        .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .vga_hs(hs0), .vga_vs(vs0), .frame_start(fs0)
    );

    framebuffer_scanout #(.CLK_DIV(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .framebuffer(fb),
        .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .vga_hs(hs1), .vga_vs(vs1), .frame_start(fs1)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Must be called an even number of clocks after reset release so the
    // CLK_DIV=2 divider is at phase 0.
    task automatic place(input int h, input int v);
        jump_h = 10'(h);
        jump_v = 10'(v);
        force dut.u_timing.h_q  = jump_h;
        force dut.u_timing.v_q  = jump_v;
        force dut1.u_timing.h_q = jump_h;
        force dut1.u_timing.v_q = jump_v;
        #1;
        release dut.u_timing.h_q;
        release dut.u_timing.v_q;
        release dut1.u_timing.h_q;
        release dut1.u_timing.v_q;
    endtask

    task automatic reset_jump(input int h, input int v);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        place(h, v);
    endtask

    // Runs through a frame wrap first so a shadow copy holds the current fb.
    task automatic load_and_place(input int h, input int v);
        reset_jump(798, 524);
        repeat (4) step();
        place(h, v);
    endtask

    function automatic logic [11:0] exp_colour(input int h, input int v, input logic [1199:0] m);
        if (h >= 640 || v >= 480) return 12'h000;
        return m[(v / 16) * 40 + (h / 16)] ? 12'hFFF : 12'h000;
    endfunction

    function automatic logic exp_hs(input int h);
        return !(h >= 656 && h <= 751);
    endfunction

    function automatic logic exp_vs(input int v);
        return !(v >= 490 && v <= 491);
    endfunction

    // Steps 2*n clocks: the CLK_DIV=1 instance shows pixel k-1 after clock k,
    // the CLK_DIV=2 instance shows pixel k/2-1 after clock k (k >= 2).
    task automatic scan_check(input string tag, input int h0, input int v0, input int n,
                              input logic [1199:0] m);
        for (int k = 1; k <= 2 * n; k++) begin
            int p, h, v;
            step();
            p = k - 1;
            h = (h0 + p) % 800;
            v = (v0 + (h0 + p) / 800) % 525;
            n_checks++;
            if ({r1, g1, b1} !== exp_colour(h, v, m) || hs1 !== exp_hs(h) || vs1 !== exp_vs(v)) begin
                n_fail++;
                $display("FAIL %s div1 pos(%0d,%0d) got rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b",
                         tag, h, v, {r1, g1, b1}, hs1, vs1, exp_colour(h, v, m), exp_hs(h), exp_vs(v));
            end
            if (k >= 2) begin
                p = k / 2 - 1;
                h = (h0 + p) % 800;
                v = (v0 + (h0 + p) / 800) % 525;
                n_checks++;
                if ({r0, g0, b0} !== exp_colour(h, v, m) || hs0 !== exp_hs(h) || vs0 !== exp_vs(v)) begin
                    n_fail++;
                    $display("FAIL %s div2 clk%0d pos(%0d,%0d) got rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b",
                             tag, k, h, v, {r0, g0, b0}, hs0, vs0, exp_colour(h, v, m), exp_hs(h), exp_vs(v));
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] first_px;
        int          fs_seen;
`ifdef SCANOUT_SHADOW_EN
        first_px = 12'h000;
`else
        first_px = 12'hFFF;
`endif
        fb = '1;
        load_and_place(100, 10);
        repeat (40) step();
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({r0, g0, b0} !== 12'h000 || {r1, g1, b1} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_colour got %h/%h expected 000", {r0, g0, b0}, {r1, g1, b1});
        end
        n_checks++;
        if ({hs0, vs0, fs0, hs1, vs1, fs1} !== 6'b110110) begin
            n_fail++;
            $display("FAIL reset_sync got %b expected 110110", {hs0, vs0, fs0, hs1, vs1, fs1});
        end
        repeat (3) step();
        n_checks++;
        if ({r0, g0, b0, hs0, vs0} !== 14'b11) begin
            n_fail++;
            $display("FAIL reset_held got %b expected 00000000000011", {r0, g0, b0, hs0, vs0});
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        n_checks++;
        if ({r0, g0, b0} !== 12'h000 || hs0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_early_tick got rgb=%h hs=%b expected 000 1", {r0, g0, b0}, hs0);
        end
        n_checks++;
        if ({r1, g1, b1} !== first_px) begin
            n_fail++;
            $display("FAIL reset_div1_first got %h expected %h", {r1, g1, b1}, first_px);
        end
        step();
        n_checks++;
        if ({r0, g0, b0} !== first_px) begin
            n_fail++;
            $display("FAIL reset_first_tick got %h expected %h", {r0, g0, b0}, first_px);
        end
        fs_seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (fs0 || fs1) fs_seen++;
        end
        n_checks++;
        if (fs_seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_frame_start got %0d pulses expected 0", fs_seen);
        end
    endtask

    task automatic test_hsync_timing();
        int   f0a = -1, r0a = -1, f0b = -1, f1a = -1, r1a = -1, f1b = -1;
        int   odd = 0;
        logic p0 = 1'b1, p1 = 1'b1;
        reset_jump(0, 0);
        for (int c = 1; c <= 3200; c++) begin
            step();
            if (p0 && !hs0) begin if (f0a < 0) f0a = c; else if (f0b < 0) f0b = c; end
            if (!p0 && hs0 && r0a < 0) r0a = c;
            if (p1 && !hs1) begin if (f1a < 0) f1a = c; else if (f1b < 0) f1b = c; end
            if (!p1 && hs1 && r1a < 0) r1a = c;
            if (!vs0 || !vs1 || fs0 || fs1) odd++;
            p0 = hs0;
            p1 = hs1;
        end
        n_checks++;
        if (f0a != 1314) begin n_fail++; $display("FAIL hs_first_fall div2 got %0d expected 1314", f0a); end
        n_checks++;
        if (r0a - f0a != 192) begin n_fail++; $display("FAIL hs_low div2 got %0d expected 192", r0a - f0a); end
        n_checks++;
        if (f0b - f0a != 1600) begin n_fail++; $display("FAIL hs_period div2 got %0d expected 1600", f0b - f0a); end
        n_checks++;
        if (f1a != 657) begin n_fail++; $display("FAIL hs_first_fall div1 got %0d expected 657", f1a); end
        n_checks++;
        if (r1a - f1a != 96) begin n_fail++; $display("FAIL hs_low div1 got %0d expected 96", r1a - f1a); end
        n_checks++;
        if (f1b - f1a != 800) begin n_fail++; $display("FAIL hs_period div1 got %0d expected 800", f1b - f1a); end
        n_checks++;
        if (odd != 0) begin n_fail++; $display("FAIL hs_line_quiet got %0d vs/frame_start events expected 0", odd); end
    endtask

    task automatic test_vsync_timing();
        int   vf0 = -1, vr0 = -1, vf1 = -1, vr1 = -1;
        logic p0 = 1'b1, p1 = 1'b1;
        reset_jump(0, 489);
        for (int c = 1; c <= 5000; c++) begin
            step();
            if (p0 && !vs0 && vf0 < 0) vf0 = c;
            if (!p0 && vs0 && vr0 < 0) vr0 = c;
            if (p1 && !vs1 && vf1 < 0) vf1 = c;
            if (!p1 && vs1 && vr1 < 0) vr1 = c;
            p0 = vs0;
            p1 = vs1;
        end
        n_checks++;
        if (vf0 != 1602) begin n_fail++; $display("FAIL vs_fall div2 got %0d expected 1602", vf0); end
        n_checks++;
        if (vr0 - vf0 != 3200) begin n_fail++; $display("FAIL vs_low div2 got %0d expected 3200", vr0 - vf0); end
        n_checks++;
        if (vf1 != 801) begin n_fail++; $display("FAIL vs_fall div1 got %0d expected 801", vf1); end
        n_checks++;
        if (vr1 - vf1 != 1600) begin n_fail++; $display("FAIL vs_low div1 got %0d expected 1600", vr1 - vf1); end
    endtask

    task automatic test_frame_start();
        int first0 = -1, first1 = -1, cnt0 = 0, cnt1 = 0;
        fb = '1;
        reset_jump(795, 524);
        for (int c = 1; c <= 30; c++) begin
            step();
            if (fs0) begin cnt0++; if (first0 < 0) first0 = c; end
            if (fs1) begin cnt1++; if (first1 < 0) first1 = c; end
            if (c == 10) begin
                n_checks++;
                if ({r0, g0, b0} !== 12'h000) begin
                    n_fail++;
                    $display("FAIL wrap_last_pixel got %h expected 000", {r0, g0, b0});
                end
            end
            if (c == 12) begin
                n_checks++;
                if ({r0, g0, b0} !== 12'hFFF) begin
                    n_fail++;
                    $display("FAIL wrap_origin_div2 got %h expected fff", {r0, g0, b0});
                end
            end
            if (c == 6) begin
                n_checks++;
                if ({r1, g1, b1} !== 12'hFFF) begin
                    n_fail++;
                    $display("FAIL wrap_origin_div1 got %h expected fff", {r1, g1, b1});
                end
            end
        end
        n_checks++;
        if (first0 != 10 || cnt0 != 1) begin
            n_fail++;
            $display("FAIL frame_start div2 got clk %0d count %0d expected clk 10 count 1", first0, cnt0);
        end
        n_checks++;
        if (first1 != 5 || cnt1 != 1) begin
            n_fail++;
            $display("FAIL frame_start div1 got clk %0d count %0d expected clk 5 count 1", first1, cnt1);
        end
    endtask

    task automatic test_mapping();
        fb = '0;
        fb[0] = 1'b1;
        load_and_place(0, 0);
        scan_check("map_bit0_row0", 0, 0, 20, fb);
        place(0, 15);
        scan_check("map_bit0_row15", 0, 15, 20, fb);
        place(0, 16);
        scan_check("map_bit0_row16", 0, 16, 12, fb);
        fb = '0;
        fb[1199] = 1'b1;
        load_and_place(616, 479);
        scan_check("map_bit1199_v479", 616, 479, 16, fb);
        place(632, 464);
        scan_check("map_bit1199_v464", 632, 464, 8, fb);
        place(616, 463);
        scan_check("map_bit1199_v463", 616, 463, 16, fb);
    endtask

    task automatic test_blanking();
        fb = '1;
        load_and_place(630, 0);
        scan_check("blank_h_edge", 630, 0, 16, fb);
        place(0, 479);
        scan_check("blank_last_line", 0, 479, 8, fb);
        place(0, 480);
        scan_check("blank_v480", 0, 480, 8, fb);
        place(790, 524);
        scan_check("blank_wrap", 790, 524, 10, fb);
    endtask

    task automatic test_shadow();
        logic [1199:0] old_fb, seen_fb;
        fb = '0;
        old_fb = fb;
        load_and_place(0, 100);
        scan_check("shadow_pre", 0, 100, 4, fb);
        fb[0] = 1'b1;
`ifdef SCANOUT_SHADOW_EN
        seen_fb = old_fb;
`else
        seen_fb = fb;
`endif
        place(0, 0);
        scan_check("shadow_same_frame", 0, 0, 20, seen_fb);
        place(796, 524);
        scan_check("shadow_next_frame", 796, 524, 12, fb);
    endtask

    initial begin
        reset_n = 1'b0;
        fb      = '0;
        jump_h  = '0;
        jump_v  = '0;
        repeat (3) @(posedge clock);
        test_reset();
        test_hsync_timing();
        test_vsync_timing();
        test_frame_start();
        test_mapping();
        test_blanking();
        test_shadow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system clocks per pixel tick (legal 1..15).
REQ-002 SHALL have parameter FG_COLOR, default 12'hFFF: RGB444 colour for framebuffer bit 1.
REQ-003 SHALL have parameter BG_COLOR, default 12'h000: RGB444 colour for framebuffer bit 0 in the visible area.
REQ-004 SHALL have port clock, input, 1: the single system clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port framebuffer, input, 1200: 40x30 cell bitmap; cell (row,col) = framebuffer[row*40+col].
REQ-007 SHALL have ports vga_r, vga_g, vga_b, output, 4 each: registered pixel colour.
REQ-008 SHALL have ports vga_hs and vga_vs, output, 1 each: registered syncs, active low.
REQ-009 SHALL have port frame_start, output, 1: one-clock pulse when scan position returns to (0,0).

Function
REQ-010 SHALL generate pixel tick every CLK_DIV clocks from a divider counter; with CLK_DIV=1 every clock is a tick.
REQ-011 SHALL keep hcount 0..799 and vcount 0..524, advanced only on ticks; hcount wraps 799->0 and increments vcount; vcount wraps 524->0 when hcount wraps.
REQ-012 SHALL treat visible area as hcount<640 and vcount<480.
REQ-013 SHALL drive vga_hs low for hcount 656..751 and vga_vs low for vcount 490..491, high otherwise.
REQ-014 SHALL map visible pixel to cell col=hcount>>4 (0..39), row=vcount>>4 (0..29); each cell is 16x16 pixels.
REQ-015 SHALL output FG_COLOR when the selected bit is 1 and BG_COLOR when 0; outside visible area all colour outputs SHALL be 0.
REQ-016 SHALL register colour and syncs on the tick edge, so outputs reflect position (h,v) one clock after the counters held (h,v); colour and syncs stay mutually aligned and are held constant between ticks.
REQ-017 SHALL pulse frame_start high for exactly one clock on the clock after the tick that wraps both counters to (0,0).
REQ-018 SHALL never index framebuffer at or beyond 1200; blanking positions SHALL not compute cell addresses used for output.

Reset
REQ-019 SHALL, while reset_n is low, force divider, hcount, vcount to 0, vga_r/g/b to 0, vga_hs and vga_vs to 1, frame_start to 0, and the shadow register (when present) to 0.
REQ-020 SHALL, on reset_n deassertion mid-frame, restart scanning at (0,0) with the first tick CLK_DIV clocks after release; no frame_start pulse is emitted for the restart itself.

Configuration
REQ-021 SHALL, with SCANOUT_SHADOW_EN defined, latch framebuffer into a 1200-bit shadow register on the tick at (799,524) and source all pixels from the shadow, giving tear-free frames.
REQ-022 SHALL, without SCANOUT_SHADOW_EN, omit the shadow register and read framebuffer live, so changes take effect on the next displayed pixel.

Structure
REQ-023 SHALL place H/V visible, porch, sync and total constants, grid width 40, height 30 and cell shift 4 in shared package display_pkg.
REQ-024 SHALL contain one sub-module vga_timing (divider, counters, sync and visible decode); scanout SHALL be its only instantiator.

Verification
REQ-025 SHALL check reset: reset_n=0 mid-frame -> r/g/b=0, hs=vs=1, frame_start=0; release -> first tick after 2 clocks, h=v=0.
REQ-026 SHALL check timing at CLK_DIV=2: hs period 1600 clocks with 192-clock low; vs period 840000 clocks with 3200-clock low; frame_start every 840000 clocks.
REQ-027 SHALL check mapping: framebuffer only bit 0 set -> pixels h0..15,v0..15 = 12'hFFF, all others 0; only bit 1199 set -> h624..639,v464..479 = 12'hFFF.
REQ-028 SHALL check blanking: framebuffer all ones -> colour 0 for h>=640 or v>=480, 12'hFFF elsewhere.
REQ-029 SHALL check shadow (macro defined): flip bit 0 at v=100 -> cell (0,0) unchanged until after next frame_start; macro undefined -> next visible cell-(0,0) pixel shows the new value.
REQ-030 SHALL check CLK_DIV=1: hs period 800 clocks, outputs change every clock, one-clock latency preserved.
